// File: rtl/zx3_joy_pkg.sv
// Shared types and defaults for the ZXTRES joystick chain readers.
// State and phase encodings used by the DB9/JAMMA deserialiser.
package zx3_joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } joy_state_e;

  typedef enum logic {
    PH_LOW,
    PH_HIGH
  } joy_phase_e;

  localparam int JOY_NBITS    = 24;
  localparam int JOY_DIV_1MHZ = 25;

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running prescaler for serial pad readers.
// tick is high for one cycle every DIV cycles.
module joy_tick_gen
  import zx3_joy_pkg::*;
#(
  parameter int DIV = JOY_DIV_1MHZ
) (
  input  logic clk50mhz,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // wrap at DIV-1, never paused by the consumer
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/db9_joy_reader.sv
// DB9/JAMMA 74HC165-style chain reader: load, shift out, commit.
// Two joystick words update together, strobed by frame_valid.
module db9_joy_reader
  import zx3_joy_pkg::*;
#(
  parameter int DIV        = JOY_DIV_1MHZ,
  parameter int NBITS      = JOY_NBITS,
  parameter int GAP        = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk50mhz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               joy_data,
  output logic               joy_clk,
  output logic               joy_load_n,
  output logic [NBITS/2-1:0] joy1,
  output logic [NBITS/2-1:0] joy2,
  output logic               frame_valid
);

  localparam int H  = NBITS / 2;
  localparam int IW = $clog2(NBITS);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic tick;
  logic bit_in;

  joy_state_e state, st_d;
  joy_phase_e phase, ph_d;
  logic [IW-1:0]    idx, idx_d;
  logic             ld_cnt, ld_d;
  logic [GW-1:0]    gap_cnt, gap_d;
  logic [NBITS-1:0] shreg, sh_d;
  logic             clk_d, load_d, fv_d;
  logic [H-1:0]     j1_d, j2_d;

  joy_tick_gen #(.DIV(DIV)) u_tick (
    .clk50mhz (clk50mhz),
    .reset_n  (reset_n),
    .tick     (tick)
  );

  assign bit_in = (ACTIVE_LOW != 0) ? ~joy_data : joy_data;

  // state, datapath and registered pad outputs
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      phase       <= PH_LOW;
      idx         <= '0;
      ld_cnt      <= 1'b0;
      gap_cnt     <= '0;
      shreg       <= '0;
      joy_clk     <= 1'b0;
      joy_load_n  <= 1'b1;
      joy1        <= '0;
      joy2        <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= st_d;
      phase       <= ph_d;
      idx         <= idx_d;
      ld_cnt      <= ld_d;
      gap_cnt     <= gap_d;
      shreg       <= sh_d;
      joy_clk     <= clk_d;
      joy_load_n  <= load_d;
      joy1        <= j1_d;
      joy2        <= j2_d;
      frame_valid <= fv_d;
    end
  end

  // next state; everything except DONE waits for a tick
  always_comb begin
    st_d   = state;
    ph_d   = phase;
    idx_d  = idx;
    ld_d   = ld_cnt;
    gap_d  = gap_cnt;
    sh_d   = shreg;
    clk_d  = joy_clk;
    load_d = joy_load_n;
    j1_d   = joy1;
    j2_d   = joy2;
    fv_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick && enable) begin
          st_d   = ST_LOAD;
          load_d = 1'b0;
          clk_d  = 1'b0;
          ld_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (tick) begin
          if (ld_cnt) begin
            st_d   = ST_SHIFT;
            load_d = 1'b1;
            idx_d  = '0;
            ph_d   = PH_LOW;
          end else begin
            ld_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (phase == PH_LOW) begin
            sh_d  = {shreg[NBITS-2:0], bit_in};
            clk_d = 1'b1;
            ph_d  = PH_HIGH;
          end else begin
            clk_d = 1'b0;
            if (idx == IDX_LAST) begin
              st_d = ST_DONE;
            end else begin
              idx_d = idx + IW'(1);
              ph_d  = PH_LOW;
            end
          end
        end
      end
      ST_DONE: begin
        j1_d  = shreg[NBITS-1:H];
        j2_d  = shreg[H-1:0];
        fv_d  = 1'b1;
        gap_d = '0;
        st_d  = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (GAP == 0 || gap_cnt == GAP_LAST) begin
            gap_d = '0;
            if (enable) begin
              st_d   = ST_LOAD;
              load_d = 1'b0;
              ld_d   = 1'b0;
            end else begin
              st_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_cnt + GW'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_db9_joy_reader.sv
// Bench for db9_joy_reader: 74HC165 chain model plus frame scoreboard.
// Two lockstep instances cover inverted and true bit polarity.
module tb_db9_joy_reader;

  localparam int DIV    = 2;
  localparam int NB     = 24;
  localparam int GAP    = 4;
  localparam int H      = NB / 2;
  localparam int PERIOD = (2 + 2 * NB + GAP) * DIV;

  logic          clk50mhz = 1'b0;
  logic          rst_n;
  logic          en;
  logic          jd;
  logic          jc0, jl0, fv0;
  logic          jc1, jl1, fv1;
  logic [H-1:0]  j1_0, j2_0, j1_1, j2_1;
  logic [NB-1:0] load_val;
  logic [NB-1:0] chain = '0;
  logic          jc_d = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int loads  = 0;
  int frames = 0;
  int pulses = 0;
  int low_len = 0;
  int cyc    = 0;
  int last_fv = 0;
  bit per_ok = 0;
  bit ld_prev = 1;
  bit clk_prev = 0;
  bit fv_prev = 0;
  logic [NB-1:0] sb[$];
  logic [NB-1:0] raw, inv;

  always #5 clk50mhz = ~clk50mhz;

  db9_joy_reader #(
    .DIV(DIV), .NBITS(NB), .GAP(GAP), .ACTIVE_LOW(1)
  ) u_inv (
    .clk50mhz    (clk50mhz),
    .reset_n     (rst_n),
    .enable      (en),
    .joy_data    (jd),
    .joy_clk     (jc0),
    .joy_load_n  (jl0),
    .joy1        (j1_0),
    .joy2        (j2_0),
    .frame_valid (fv0)
  );

  db9_joy_reader #(
    .DIV(DIV), .NBITS(NB), .GAP(GAP), .ACTIVE_LOW(0)
  ) u_raw (
    .clk50mhz    (clk50mhz),
    .reset_n     (rst_n),
    .enable      (en),
    .joy_data    (jd),
    .joy_clk     (jc1),
    .joy_load_n  (jl1),
    .joy1        (j1_1),
    .joy2        (j2_1),
    .frame_valid (fv1)
  );

  // chain output is garbage while joy_clk is high
  assign jd = jc0 ? ~chain[NB-1] : chain[NB-1];

  always @(posedge clk50mhz) begin
    jc_d <= jc0;
    if (!jl0)
      chain <= load_val;
    else if (jc0 && !jc_d)
      chain <= {chain[NB-2:0], 1'b0};
  end

  task automatic chk(input string tag,
                     input int unsigned got,
                     input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk50mhz) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      per_ok   = 0;
      pulses   = 0;
      ld_prev  = 1;
      clk_prev = 0;
      fv_prev  = 0;
    end else begin
      if (!jl0 && jc0) viol++;
      if (!jl1 && jc1) viol++;
      if (fv0 && fv_prev) viol++;
      if (!jl0 && ld_prev) begin
        sb.push_back(load_val);
        loads++;
        low_len = 0;
        pulses  = 0;
      end
      if (!jl0) low_len++;
      if (jl0 && !ld_prev) chk("load_len", low_len, 2 * DIV);
      if (jc0 && !clk_prev) pulses++;
      if (fv0) begin
        chk("pulses", pulses, NB);
        chk("fv_raw", fv1, 1);
        if (sb.size() == 0) begin
          chk("sb_empty", 0, 1);
        end else begin
          raw = sb.pop_front();
          inv = ~raw;
          chk("joy1_inv", j1_0, inv[NB-1:H]);
          chk("joy2_inv", j2_0, inv[H-1:0]);
          chk("joy1_raw", j1_1, raw[NB-1:H]);
          chk("joy2_raw", j2_1, raw[H-1:0]);
        end
        if (per_ok) chk("period", cyc - last_fv, PERIOD);
        last_fv = cyc;
        per_ok  = en;
        frames++;
      end
      ld_prev  = jl0;
      clk_prev = jc0;
      fv_prev  = fv0;
    end
  end

  task automatic wait_frame();
    int f0 = frames;
    int n  = 0;
    while (frames == f0 && n < 2000) begin
      @(posedge clk50mhz);
      n++;
    end
    if (frames == f0) chk("frame_tmo", 0, 1);
  endtask

  task automatic wait_pulses(input int k);
    int n = 0;
    while (pulses != k && n < 2000) begin
      @(posedge clk50mhz);
      n++;
    end
    if (pulses != k) chk("pulse_tmo", pulses, k);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_clk"}, {jc1, jc0}, 0);
    chk({tag, "_load"}, {jl1, jl0}, 3);
    chk({tag, "_joy"}, {j1_0, j2_0}, 0);
    chk({tag, "_joyr"}, {j1_1, j2_1}, 0);
    chk({tag, "_fv"}, {fv1, fv0}, 0);
  endtask

  initial begin
    int l0;
    int lat;
    rst_n    = 1'b0;
    en       = 1'b1;
    load_val = 24'hF0F0F0;
    repeat (3) @(negedge clk50mhz);
    #1 chk_reset_outs("rst");
    @(negedge clk50mhz);
    rst_n = 1'b1;

    wait_frame();
    load_val = 24'h800001;
    wait_frame();
    wait_frame();
    load_val = 24'($urandom);
    wait_frame();
    load_val = 24'($urandom);
    wait_frame();

    load_val = 24'h3C5A96;
    wait_pulses(10);
    @(negedge clk50mhz);
    en = 1'b0;
    wait_frame();
    l0 = loads;
    repeat (300) @(posedge clk50mhz);
    chk("idle_loads", loads - l0, 0);
    chk("idle_load_n", jl0, 1);

    load_val = 24'h0FF00F;
    @(negedge clk50mhz);
    en  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk50mhz);
      lat++;
    end while (jl0 && lat < 10);
    chk("en_latency", (lat >= 1 && lat <= DIV), 1);
    wait_frame();

    load_val = 24'h123456;
    wait_pulses(12);
    @(negedge clk50mhz);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    repeat (5) @(negedge clk50mhz);
    load_val = 24'hA5C3E1;
    rst_n = 1'b1;
    wait_frame();
    load_val = 24'h5A5A5A;
    wait_frame();

    repeat (4) @(posedge clk50mhz);
    chk("proto_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
